bcd_conv_sched: RTL and testbench

Round-robin scheduler that time-shares a single combinational 6-bit-binary-to-BCD converter among NUM_CH requesters (seconds, minutes, hours, day counters of the clock).
It accepts per-channel req/ack handshakes and latches the requesting channel's binary value onto the shared converter input.
It captures the converter's BCD result into a per-channel result register and pulses that channel's ack.
It sits between the time counters and the display/digit-driver logic.

---
 rtl/bcd_conv_sched.sv | 132 +++++++++++++
 tb/tb_bcd_conv_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bcd_conv_sched
//  Brief    : Round-robin scheduler that time-shares one combinational
//             binary-to-BCD converter among NUM_CH req/ack requesters.
//             Each conversion runs IDLE -> CONV -> ACK (3 cycles); the
//             operand is latched at grant so later bin_in changes are
//             ignored, and the result lands in a per-channel register.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_conv_sched #(
    parameter int NUM_CH = 4,
    parameter int BIN_W  = 6,
    parameter int BCD_W  = 8,
    parameter int ID_W   = $clog2(NUM_CH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         req,
    input  logic [NUM_CH*BIN_W-1:0]   bin_in,
    output logic [BIN_W-1:0]          conv_bin,
    input  logic [BCD_W-1:0]          conv_bcd,
    output logic [NUM_CH-1:0]         ack,
    output logic [NUM_CH*BCD_W-1:0]   bcd_out,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy
);

    localparam logic [1:0]        c_IDLE    = 2'd0;
    localparam logic [1:0]        c_CONV    = 2'd1;
    localparam logic [1:0]        c_ACK     = 2'd2;
    localparam logic [ID_W-1:0]   c_LAST_CH = ID_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0] c_ONE     = NUM_CH'(1);

    logic [1:0]              r_state;
    logic [ID_W-1:0]         r_last;
    logic [ID_W-1:0]         r_grant;
    logic [BIN_W-1:0]        r_conv_bin;
    logic [NUM_CH-1:0]       r_ack;
    logic [NUM_CH*BCD_W-1:0] r_bcd;

    logic [ID_W-1:0]         w_sel;
    logic [ID_W-1:0]         w_idx;
    logic                    w_any;
    logic [BIN_W-1:0]        w_bin;

    // Round-robin search starting one past the last granted channel; the
    // first requester found in wrap-around order wins.
    always_comb begin
        w_sel = r_last;
        w_any = 1'b0;
        w_idx = r_last;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_idx == c_LAST_CH) begin
                w_idx = '0;
            end else begin
                w_idx = w_idx + ID_W'(1);
            end
            if (!w_any && req[w_idx]) begin
                w_sel = w_idx;
                w_any = 1'b1;
            end
        end
    end

    // Operand mux: binary value of the channel the search selected.
    always_comb begin
        w_bin = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (w_sel == ID_W'(k)) begin
                w_bin = bin_in[k*BIN_W +: BIN_W];
            end
        end
    end

    // Control FSM: grant and latch operand in IDLE, pulse ack leaving CONV,
    // return to IDLE after the single ACK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_last     <= c_LAST_CH;
            r_grant    <= '0;
            r_conv_bin <= '0;
            r_ack      <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                c_IDLE: begin
                    if (w_any) begin
                        r_grant    <= w_sel;
                        r_conv_bin <= w_bin;
                        r_last     <= w_sel;
                        r_state    <= c_CONV;
                    end
                end
                c_CONV: begin
                    r_ack   <= c_ONE << r_grant;
                    r_state <= c_ACK;
                end
                c_ACK: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Result capture: only the granted channel's slot is written, at the
    // end of CONV when the shared converter output has settled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bcd <= '0;
        end else if (r_state == c_CONV) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (r_grant == ID_W'(k)) begin
                    r_bcd[k*BCD_W +: BCD_W] <= conv_bcd;
                end
            end
        end
    end

    assign conv_bin = r_conv_bin;
    assign ack      = r_ack;
    assign bcd_out  = r_bcd;
    assign grant_id = r_grant;
    assign busy     = (r_state != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_bcd_conv_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bcd_conv_sched
//  Brief    : Self-checking bench for bcd_conv_sched with a behavioural
//             converter, directed scenarios and randomized request batches.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_conv_sched;

    localparam int NUM_CH = 4;
    localparam int BIN_W  = 6;
    localparam int BCD_W  = 8;
    localparam int ID_W   = 2;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_CH-1:0]       req;
    logic [NUM_CH*BIN_W-1:0] bin_in;
    logic [BIN_W-1:0]        conv_bin;
    logic [BCD_W-1:0]        conv_bcd;
    logic [NUM_CH-1:0]       ack;
    logic [NUM_CH*BCD_W-1:0] bcd_out;
    logic [ID_W-1:0]         grant_id;
    logic                    busy;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: last granted channel, stored results, held operand.
    int         m_last;
    logic [7:0] m_bcd [NUM_CH];
    logic [5:0] m_conv;

    always #5 clk = ~clk;

    // Shared converter: two decimal digits of the operand.
    assign conv_bcd = {4'(conv_bin / 6'd10), 4'(conv_bin % 6'd10)};

    bcd_conv_sched #(
        .NUM_CH (NUM_CH),
        .BIN_W  (BIN_W),
        .BCD_W  (BCD_W),
        .ID_W   (ID_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .bin_in   (bin_in),
        .conv_bin (conv_bin),
        .conv_bcd (conv_bcd),
        .ack      (ack),
        .bcd_out  (bcd_out),
        .grant_id (grant_id),
        .busy     (busy)
    );

    function automatic logic [7:0] to_bcd(input int v);
        return 8'(((v / 10) * 16) + (v % 10));
    endfunction

    function automatic int rr_pick(input int last, input logic [NUM_CH-1:0] r);
        for (int off = 1; off <= NUM_CH; off++) begin
            if (r[(last + off) % NUM_CH]) return (last + off) % NUM_CH;
        end
        return 0;
    endfunction

    function automatic logic [NUM_CH*BCD_W-1:0] model_vec();
        logic [NUM_CH*BCD_W-1:0] v;
        for (int k = 0; k < NUM_CH; k++) v[k*BCD_W +: BCD_W] = m_bcd[k];
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_last = NUM_CH - 1;
        m_conv = '0;
        for (int k = 0; k < NUM_CH; k++) m_bcd[k] = 8'h00;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ack"},      ack, 0);
        check({tag, "_busy"},     busy, 0);
        check({tag, "_grant"},    grant_id, 0);
        check({tag, "_conv_bin"}, conv_bin, 0);
        check({tag, "_bcd_out"},  bcd_out, 0);
    endtask

    // One full conversion starting in IDLE with req already driven.
    // want_ch / want_bcd >= 0 impose directed expectations, else the model decides.
    task automatic do_conv(input int want_ch, input int want_bcd);
        int ch;
        logic [5:0] v;
        logic [7:0] b;
        ch = (want_ch >= 0) ? want_ch : rr_pick(m_last, req);
        v  = bin_in[ch*BIN_W +: BIN_W];
        b  = (want_bcd >= 0) ? 8'(want_bcd) : to_bcd(int'(v));
        step();
        check("grant_id",  grant_id, 64'(ch));
        check("conv_bin",  conv_bin, v);
        check("busy_conv", busy, 1);
        check("ack_conv",  ack, 0);
        m_last = ch;
        m_conv = v;
        step();
        m_bcd[ch] = b;
        check("ack_pulse", ack, 64'(1) << ch);
        check("bcd_out",   bcd_out, model_vec());
        check("busy_ack",  busy, 1);
        if (ack[ch]) req[ch] = 1'b0;
        step();
        check("ack_clear", ack, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int bv [5] = '{0, 9, 10, 59, 63};
        int be [5] = '{'h00, 'h09, 'h10, 'h59, 'h63};
        int gap;

        rst    = 1'b1;
        req    = '0;
        bin_in = '0;
        model_reset();
        #3;
        check_reset_outputs("por");
        step();
        step();
        rst = 1'b0;

        // Single request on ch1, others untouched.
        bin_in = {6'd7, 6'd3, 6'd45, 6'd21};
        req    = 4'b0010;
        do_conv(1, 'h45);

        // Reset again so the pointer starts from ch0 for the batch test.
        rst = 1'b1;
        #1;
        check_reset_outputs("rst2");
        step();
        rst = 1'b0;
        model_reset();

        // All four at once: served ch0..ch3 in order.
        bin_in = {6'd7, 6'd56, 6'd34, 6'd12};
        req    = 4'b1111;
        do_conv(0, 'h12);
        do_conv(1, 'h34);
        do_conv(2, 'h56);
        do_conv(3, 'h07);

        // Fairness: ch2 served, then ch0 and ch3 together -> ch3 first.
        req = 4'b0100;
        do_conv(2, -1);
        req = 4'b1001;
        do_conv(3, -1);
        do_conv(0, -1);

        // Boundary values through ch0, including out-of-range 63.
        for (int i = 0; i < 5; i++) begin
            bin_in[0 +: BIN_W] = 6'(bv[i]);
            req = 4'b0001;
            do_conv(0, be[i]);
        end

        // Drop request and change operand during CONV.
        bin_in[2*BIN_W +: BIN_W] = 6'd30;
        req = 4'b0100;
        step();
        check("dm_grant", grant_id, 2);
        check("dm_conv_bin", conv_bin, 30);
        req[2] = 1'b0;
        bin_in[2*BIN_W +: BIN_W] = 6'd31;
        step();
        m_bcd[2] = 8'h30;
        m_last   = 2;
        m_conv   = 6'd30;
        check("dm_ack", ack, 4'b0100);
        check("dm_bcd_out", bcd_out, model_vec());
        step();
        check("dm_ack_clear", ack, 0);
        check("dm_busy", busy, 0);

        // Randomized batches against the round-robin model.
        for (int it = 0; it < 25; it++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                step();
                check("idle_busy", busy, 0);
                check("idle_conv_hold", conv_bin, m_conv);
            end
            for (int k = 0; k < NUM_CH; k++) bin_in[k*BIN_W +: BIN_W] = 6'($urandom_range(0, 63));
            req = 4'($urandom_range(1, 15));
            for (int g = 0; g < NUM_CH && req != 0; g++) do_conv(-1, -1);
            check("drained", req, 0);
            req = '0;
        end

        // Reset during CONV discards the conversion.
        bin_in[1*BIN_W +: BIN_W] = 6'd17;
        req = 4'b0010;
        step();
        check("rc_grant", grant_id, 1);
        #2;
        rst = 1'b1;
        req = '0;
        #1;
        check_reset_outputs("rc");
        step();
        check("rc_ack_in_rst", ack, 0);
        rst = 1'b0;
        model_reset();
        step();
        check("rc_ack_after", ack, 0);
        check("rc_busy_after", busy, 0);
        req = 4'b1011;
        do_conv(0, -1);
        req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
